// File: rtl/ssd_score_ctrl_pkg.sv
// Shared definitions for the score display: segment patterns, blank pattern,
// converter state encodings and small constant helpers.
package ssd_score_ctrl_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // abcdefg, active-low, a is the MSB
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

endpackage

// File: rtl/ssd_score_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter with valid/ready intake and a one-cycle
// done pulse; out-of-range scores are flagged at intake and reported as all nines.
//
// state     | meaning
// ST_IDLE   | ready, waiting for a score
// ST_SHIFT  | one add-3/shift iteration per clock, BIN_W iterations
// ST_COMMIT | result valid on bcd, done pulsed
module ssd_score_ctrl_bin2bcd_seq
  import ssd_score_ctrl_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  ClkPort,
  input  logic                  Reset_n,
  input  logic [BIN_W-1:0]      score_in,
  input  logic                  score_valid,
  output logic                  score_ready,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [31:0] SAT_LIMIT = pow10(DIGITS);

  conv_state_e        state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    score_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    adj         = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        score_ready = 1'b1;
        if (score_valid) begin
          bin_d   = score_in;
          bcd_d   = '0;
          cnt_d   = '0;
          sat_d   = (32'(score_in) >= SAT_LIMIT);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy  = 1'b1;
        // top BCD bit falls off; only matters for saturated values
        bcd_d = BCD_W'({adj, bin_q[BIN_W-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bcd = sat_q ? {DIGITS{4'd9}} : bcd_q;

endmodule

// File: rtl/ssd_score_ctrl.sv
// Score display top: BCD converter, display registers and digit scan onto
// active-low pins. Optional leading-zero blanking via SSD_LEADING_ZERO_BLANK_EN.
module ssd_score_ctrl
  import ssd_score_ctrl_pkg::*;
#(
  parameter int BIN_W      = 14,
  parameter int DIGITS     = 4,
  parameter int SCAN_SHIFT = 18
) (
  input  logic                ClkPort,
  input  logic                Reset_n,
  input  logic [BIN_W-1:0]    score_in,
  input  logic                score_valid,
  output logic                score_ready,
  input  logic [DIGITS-1:0]   dp_mask,
  output logic                busy,
  output logic [7:0]          An,
  output logic [7:0]          Cath
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0]  bcd;
  logic                 done;
  logic [4*DIGITS-1:0]  disp_q;
  logic [SCAN_SHIFT-1:0] presc_q;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           an_q, cath_q, an_d, cath_d;
  logic [DIGITS-1:0]    blank_v;
  logic [3:0]           nib;
  logic                 dp_on, blank;

  ssd_score_ctrl_bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .ClkPort     (ClkPort),
    .Reset_n     (Reset_n),
    .score_in    (score_in),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .busy        (busy),
    .bcd         (bcd),
    .done        (done)
  );

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      an_q    <= 8'hFF;
      cath_q  <= SEG_OFF;
    end else begin
      presc_q <= presc_q + SCAN_SHIFT'(1);
      if (&presc_q) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      if (done) disp_q <= bcd;
      an_q   <= an_d;
      cath_q <= cath_d;
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic all_zero;
  always_comb begin
    all_zero = 1'b1;
    blank_v  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (disp_q[4*i +: 4] == 4'd0);
      blank_v[i] = all_zero && (i > 0);
    end
  end
`else
  assign blank_v = '0;
`endif

  // anode and cathode come from the same index in the same cycle
  always_comb begin
    nib    = 4'd0;
    dp_on  = 1'b0;
    blank  = 1'b0;
    an_d   = 8'hFF;
    cath_d = SEG_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib     = disp_q[4*i +: 4];
        dp_on   = dp_mask[i];
        blank   = blank_v[i];
        an_d[i] = 1'b0;
      end
    end
    cath_d = {hex_to_seg(nib), ~dp_on};
    if (blank) begin
      an_d   = 8'hFF;
      cath_d = SEG_OFF;
    end
  end

  assign An   = an_q;
  assign Cath = cath_q;

endmodule
